// File: rtl/lic_timer_sched_pkg.sv
// Shared types and helpers for the virtual timer scheduler.
package lic_timer_sched_pkg;

  // Timer / deadline width, matching the machine timer of the core.
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PROGRAM = 2'd2
  } sched_state_e;

  // "a before-or-at b" on a wrapping counter: signed (a - b) <= 0.
  function automatic logic before_or_at(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    logic [XLEN-1:0] diff;
    diff = a - b;
    return diff[XLEN-1] || (diff == '0);
  endfunction

  // "a strictly before b" on a wrapping counter: signed (a - b) < 0.
  function automatic logic strictly_before(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic [XLEN-1:0] diff;
    diff = a - b;
    return diff[XLEN-1];
  endfunction

endpackage

// File: rtl/lic_sched_chan.sv
// One virtual timer channel: armed/pending flags, deadline and expiry compare.
module lic_sched_chan
  import lic_timer_sched_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            arm,
  input  logic            cancel,
  input  logic            ack,
  input  logic [XLEN-1:0] new_deadline,
  input  logic [XLEN-1:0] mtime,
  output logic            armed,
  output logic            pending,
  output logic            expire,
  output logic [XLEN-1:0] deadline
);

  assign expire = armed && before_or_at(deadline, mtime);

  // Armed/pending flags: a fresh arm wins over an expiry of the old deadline,
  // and an expiry wins over an ack of the same channel.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      armed   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (arm)                  armed <= 1'b1;
      else if (cancel || expire) armed <= 1'b0;

      if (expire)   pending <= 1'b1;
      else if (ack) pending <= 1'b0;
    end
  end

  // Deadline register, loaded on every accepted arm request.
  always_ff @(posedge clk) begin
    // NOTE: deadline storage is reset so a scan never sees X before first arm.
    if (reset)    deadline <= '0;
    else if (arm) deadline <= new_deadline;
  end

endmodule

// File: rtl/lic_timer_sched.sv
// Shares the machine-timer comparator between NUM_CH virtual timer channels.
module lic_timer_sched
  import lic_timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cancel,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [XLEN-1:0]   req_deadline,
  input  logic              ack_valid,
  input  logic [CH_W-1:0]   ack_ch,
  input  logic [XLEN-1:0]   lic_mtime_read,
  output logic [XLEN-1:0]   lic_mtimecmp_write,
  output logic              lic_mtimecmp_write_ena,
  output logic [NUM_CH-1:0] ch_armed,
  output logic [NUM_CH-1:0] ch_pending,
  output logic              sched_irq,
  output logic              sched_busy
);

  sched_state_e      state;
  logic              dirty;
  logic              found;
  logic [CH_W-1:0]   idx;
  logic [XLEN-1:0]   best;
  logic [NUM_CH-1:0] expire;
  logic [XLEN-1:0]   deadline [NUM_CH];
  logic              accept;
  logic              any_expire;
  logic              take;
  logic              next_found;
  logic [XLEN-1:0]   next_best;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign any_expire = |expire;
  assign sched_irq  = |ch_pending;
  assign sched_busy = (state != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lic_sched_chan u_chan (
      .clk          (clk),
      .reset        (reset),
      .arm          (accept && !req_cancel && (req_ch == CH_W'(i))),
      .cancel       (accept &&  req_cancel && (req_ch == CH_W'(i))),
      .ack          (ack_valid && (ack_ch == CH_W'(i))),
      .new_deadline (req_deadline),
      .mtime        (lic_mtime_read),
      .armed        (ch_armed[i]),
      .pending      (ch_pending[i]),
      .expire       (expire[i]),
      .deadline     (deadline[i])
    );
  end

  // Running-minimum update for the channel visited this scan cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_best  = best;
    next_found = found;
    take       = ch_armed[idx] && (!found || strictly_before(deadline[idx], best));
    if (take) begin
      next_best  = deadline[idx];
      next_found = 1'b1;
    end
  end

  // Scheduler FSM: wait for a change, scan all channels, program the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      dirty                  <= 1'b0;
      idx                    <= '0;
      found                  <= 1'b0;
      best                   <= '0;
      lic_mtimecmp_write     <= '0;
      lic_mtimecmp_write_ena <= 1'b0;
    end else begin
      lic_mtimecmp_write_ena <= 1'b0;
      case (state)
        IDLE: begin
          // An expiry in the launch cycle is already visible to the scan,
          // so dirty can be cleared unconditionally here.
          if (dirty && !accept) begin
            state <= SCAN;
            dirty <= 1'b0;
            idx   <= '0;
            found <= 1'b0;
          end else if (accept || any_expire) begin
            dirty <= 1'b1;
          end
        end
        SCAN: begin
          if (any_expire) dirty <= 1'b1;
          best  <= next_best;
          found <= next_found;
          idx   <= idx + 1'b1;
          if (idx == CH_W'(NUM_CH - 1)) begin
            state <= PROGRAM;
            // The strobe is registered so it is high during the PROGRAM cycle.
            if (next_found) begin
              lic_mtimecmp_write     <= next_best;
              lic_mtimecmp_write_ena <= 1'b1;
            end
          end
        end
        PROGRAM: begin
          if (any_expire) dirty <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
